fpnew_pipe_elastic: RTL and testbench



---
 rtl/fpnew_pipe_elastic.sv | 149 ++++++++++++++
 tb/tb_fpnew_pipe_elastic.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_pipe_elastic.sv
// Elastic valid/ready pipeline for FP units: NumPipeRegs stages, flush, occupancy, bubble collapsing.
// Define FPNEW_PIPE_SKID_EN to add a one-entry output skid register that cuts out_ready_i -> in_ready_o.
module fpnew_pipe_elastic #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned NumPipeRegs = 2,
  parameter int unsigned OccWidth    = $clog2(NumPipeRegs + 2)
) (
  input  logic                                           clk_i,
  input  logic                                           rst_ni,
  input  logic [DataWidth-1:0]                           data_i,
  input  logic                                           in_valid_i,
  output logic                                           in_ready_o,
  input  logic                                           flush_i,
  output logic [DataWidth-1:0]                           data_o,
  output logic                                           out_valid_o,
  input  logic                                           out_ready_i,
  output logic [((NumPipeRegs > 0) ? NumPipeRegs : 1)-1:0] stage_valid_o,
  output logic [OccWidth-1:0]                            occupancy_o,
  output logic                                           busy_o
);

  if (NumPipeRegs == 0) begin : g_bypass
    assign data_o        = data_i;
    assign out_valid_o   = in_valid_i;
    assign in_ready_o    = out_ready_i;
    assign stage_valid_o = '0;
    assign occupancy_o   = '0;
    assign busy_o        = in_valid_i;
  end else begin : g_pipe
    localparam int unsigned N = NumPipeRegs;

    logic [N-1:0]         valid_q;
    logic [N-1:0]         valid_d;
    logic [N-1:0]         ready_s;
    logic [DataWidth-1:0] data_q [N];
    logic                 last_ready_s;
    logic                 ready_acc_s;
    logic                 skid_valid_s;
    logic [OccWidth-1:0]  occ_s;

    always_comb begin
      valid_d    = '0;
      valid_d[0] = in_valid_i;
      for (int i = 1; i < int'(N); i++) begin
        valid_d[i] = valid_q[i-1];
      end
    end

    // A stage may advance if anything downstream of it (itself included) has a free slot.
    always_comb begin
      ready_acc_s = last_ready_s;
      ready_s     = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
        ready_acc_s = ready_acc_s | ~valid_q[i];
        ready_s[i]  = ready_acc_s;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
      end else if (flush_i) begin
        valid_q <= '0;
      end else begin
        for (int i = 0; i < int'(N); i++) begin
          if (ready_s[i]) begin
            valid_q[i] <= valid_d[i];
          end
        end
      end
    end

    // Payload registers only load real items and are left untouched by flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(N); i++) begin
          data_q[i] <= '0;
        end
      end else begin
        if (ready_s[0] && valid_d[0]) begin
          data_q[0] <= data_i;
        end
        for (int i = 1; i < int'(N); i++) begin
          if (ready_s[i] && valid_d[i]) begin
            data_q[i] <= data_q[i-1];
          end
        end
      end
    end

`ifdef FPNEW_PIPE_SKID_EN
    logic                 skid_valid_q;
    logic                 skid_valid_d;
    logic                 skid_load_s;
    logic [DataWidth-1:0] skid_data_q;

    assign last_ready_s = ~skid_valid_q;
    assign skid_load_s  = ~skid_valid_q & valid_q[N-1] & ~out_ready_i;

    always_comb begin
      if (skid_valid_q) begin
        skid_valid_d = ~out_ready_i;
      end else begin
        skid_valid_d = valid_q[N-1] & ~out_ready_i;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        skid_valid_q <= 1'b0;
      end else if (flush_i) begin
        skid_valid_q <= 1'b0;
      end else begin
        skid_valid_q <= skid_valid_d;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        skid_data_q <= '0;
      end else if (skid_load_s) begin
        skid_data_q <= data_q[N-1];
      end
    end

    assign skid_valid_s = skid_valid_q;
    assign out_valid_o  = skid_valid_q | valid_q[N-1];
    assign data_o       = skid_valid_q ? skid_data_q : data_q[N-1];
`else
    assign last_ready_s = out_ready_i;
    assign skid_valid_s = 1'b0;
    assign out_valid_o  = valid_q[N-1];
    assign data_o       = data_q[N-1];
`endif

    always_comb begin
      occ_s = OccWidth'(skid_valid_s);
      for (int i = 0; i < int'(N); i++) begin
        occ_s = occ_s + OccWidth'(valid_q[i]);
      end
    end

    assign in_ready_o    = ready_s[0];
    assign stage_valid_o = valid_q;
    assign occupancy_o   = occ_s;
    assign busy_o        = in_valid_i | (|valid_q) | skid_valid_s;
  end

endmodule

// File: tb/tb_fpnew_pipe_elastic.sv
// Self-checking bench for fpnew_pipe_elastic: N=2 (queue model + random traffic), N=3 directed, N=0 bypass.
module tb_fpnew_pipe_elastic;
  localparam int DW = 8;
`ifdef FPNEW_PIPE_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] a_din, a_dout;
  logic          a_iv, a_ir, a_fl, a_ov, a_or, a_busy;
  logic [1:0]    a_sv;
  logic [1:0]    a_occ;

  logic [DW-1:0] b_din, b_dout;
  logic          b_iv, b_ir, b_fl, b_ov, b_or, b_busy;
  logic [2:0]    b_sv;
  logic [2:0]    b_occ;

  logic [DW-1:0] c_din, c_dout;
  logic          c_iv, c_ir, c_fl, c_ov, c_or, c_busy;
  logic [0:0]    c_sv;
  logic [0:0]    c_occ;

  fpnew_pipe_elastic #(.DataWidth(DW), .NumPipeRegs(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(a_din), .in_valid_i(a_iv), .in_ready_o(a_ir),
    .flush_i(a_fl), .data_o(a_dout), .out_valid_o(a_ov), .out_ready_i(a_or),
    .stage_valid_o(a_sv), .occupancy_o(a_occ), .busy_o(a_busy));

  fpnew_pipe_elastic #(.DataWidth(DW), .NumPipeRegs(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(b_din), .in_valid_i(b_iv), .in_ready_o(b_ir),
    .flush_i(b_fl), .data_o(b_dout), .out_valid_o(b_ov), .out_ready_i(b_or),
    .stage_valid_o(b_sv), .occupancy_o(b_occ), .busy_o(b_busy));

  fpnew_pipe_elastic #(.DataWidth(DW), .NumPipeRegs(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(c_din), .in_valid_i(c_iv), .in_ready_o(c_ir),
    .flush_i(c_fl), .data_o(c_dout), .out_valid_o(c_ov), .out_ready_i(c_or),
    .stage_valid_o(c_sv), .occupancy_o(c_occ), .busy_o(c_busy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model for the N=2 instance: a FIFO of items held, capacity 2 (+1 with skid).
  logic [DW-1:0] q[$];
  logic          pend_pop, pend_push, pend_flush;
  logic [DW-1:0] pend_data;
  int            n_acc = 0;

  task automatic a_sample();
    @(negedge clk);
    chk("a_occ", a_occ, q.size());
    chk("a_busy", a_busy, a_iv | (q.size() != 0));
    chk("a_in_ready", a_ir, (q.size() < 2 + SKID) | ((SKID == 0) & a_or));
    chk("a_valid_without_item", a_ov & (q.size() == 0), 1'b0);
    pend_pop = a_ov & a_or;
    if (pend_pop && q.size() > 0) chk("a_data_order", a_dout, q[0]);
    pend_push  = a_iv & a_ir;
    pend_data  = a_din;
    pend_flush = a_fl;
  endtask

  task automatic a_tick();
    @(posedge clk);
    if (pend_pop && q.size() > 0) void'(q.pop_front());
    if (pend_flush) q.delete();
    else if (pend_push) begin
      q.push_back(pend_data);
      n_acc++;
    end
    #1;
  endtask

  initial begin
    int  cyc;
    logic ir_before;
    rst_n = 1'b0;
    a_din = '0; a_iv = 1'b1; a_fl = 1'b0; a_or = 1'b0;
    b_din = '0; b_iv = 1'b0; b_fl = 1'b0; b_or = 1'b0;
    c_din = '0; c_iv = 1'b0; c_fl = 1'b0; c_or = 1'b0;
    #2;
    chk("rst_out_valid", a_ov, 1'b0);
    chk("rst_data", a_dout, 8'h00);
    chk("rst_occ", a_occ, 2'd0);
    chk("rst_stage_valid", a_sv, 2'b00);
    chk("rst_in_ready", a_ir, 1'b1);
    chk("rst_busy", a_busy, 1'b1);
    chk("rst_in_ready_n3", b_ir, 1'b1);
    a_iv = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // N=2 stream 1..8 at full throughput: first output two cycles after first accept.
    a_or = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      a_iv  = (t < 8);
      a_din = DW'(t + 1);
      a_sample();
      chk("a_stream_valid", a_ov, (t >= 2) && (t < 10));
      if (t >= 2 && t < 10) chk("a_stream_data", a_dout, t - 1);
      a_tick();
    end

    // Random traffic, random backpressure and occasional flush.
    cyc = 0;
    while (n_acc < 1000 && cyc < 6000) begin
      a_fl  = ($urandom_range(0, 49) == 0);
      a_iv  = ($urandom_range(0, 3) != 0);
      a_din = DW'(cyc);
      #1;
      ir_before = a_ir;
      a_or = 1'($urandom_range(0, 1));
      #1;
      chk("a_ready_vs_out_ready", a_ir, (SKID != 0) ? ir_before : ((q.size() < 2) | a_or));
      a_sample();
      a_tick();
      cyc++;
    end
    chk("a_items_accepted", n_acc >= 1000, 1'b1);
    a_iv = 1'b0; a_fl = 1'b0; a_or = 1'b1;
    for (int t = 0; t < 10; t++) begin
      a_sample();
      a_tick();
    end
    chk("a_drained", q.size(), 0);

    // N=3 single item moves past empty stages while output is stalled.
    b_or = 1'b0; b_iv = 1'b1; b_din = 8'h55;
    @(negedge clk); chk("b_bubble_ready", b_ir, 1'b1);
    @(posedge clk); #1; b_iv = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk); chk("b_bubble_ready", b_ir, 1'b1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("b_bubble_stage", b_sv, 3'b100);
    chk("b_bubble_ready", b_ir, 1'b1);
    chk("b_bubble_valid", b_ov, 1'b1);
    chk("b_bubble_data", b_dout, 8'h55);
    chk("b_bubble_occ", b_occ, 3'd1);
    @(posedge clk); #1; b_or = 1'b1;
    @(negedge clk); chk("b_bubble_out", b_dout, 8'h55); chk("b_bubble_out_v", b_ov, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); chk("b_empty_occ", b_occ, 3'd0); chk("b_empty_valid", b_ov, 1'b0);
    @(posedge clk); #1;

    // N=3 fill under stall, then drain in order.
    b_or = 1'b0;
    for (int i = 0; i < 3 + SKID; i++) begin
      b_iv = 1'b1; b_din = 8'hA0 + 8'(i);
      @(posedge clk); #1;
    end
    b_iv = 1'b0;
    @(negedge clk);
    chk("b_full_occ", b_occ, 3 + SKID);
    chk("b_full_ready", b_ir, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); chk("b_full_hold", b_occ, 3 + SKID);
    @(posedge clk); #1;
    b_or = 1'b1;
    for (int k = 0; k < 3 + SKID; k++) begin
      @(negedge clk);
      chk("b_drain_valid", b_ov, 1'b1);
      chk("b_drain_data", b_dout, 8'hA0 + k);
      @(posedge clk); #1;
    end
    @(negedge clk); chk("b_drain_end", b_ov, 1'b0); chk("b_drain_occ", b_occ, 3'd0);
    @(posedge clk); #1;

    // N=3 flush with three items in flight and 0x77 offered in the flush cycle.
    for (int i = 0; i < 3; i++) begin
      b_iv = 1'b1; b_din = 8'hB0 + 8'(i);
      @(posedge clk); #1;
    end
    b_fl = 1'b1; b_din = 8'h77;
    @(negedge clk);
    chk("b_flush_pre_occ", b_occ, 3'd3);
    chk("b_flush_out_v", b_ov, 1'b1);
    chk("b_flush_out_d", b_dout, 8'hB0);
    chk("b_flush_ready", b_ir, 1'b1);
    @(posedge clk); #1;
    b_fl = 1'b0; b_iv = 1'b0;
    @(negedge clk);
    chk("b_flush_occ", b_occ, 3'd0);
    chk("b_flush_valid", b_ov, 1'b0);
    chk("b_flush_stages", b_sv, 3'b000);
    chk("b_flush_busy", b_busy, 1'b0);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      @(negedge clk); chk("b_flush_no_emit", b_ov, 1'b0);
    end
    @(posedge clk); #1;

    // Asynchronous reset drops in-flight items immediately.
    b_or = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_iv = 1'b1; b_din = 8'hC0 + 8'(i);
      @(posedge clk); #1;
    end
    b_iv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("b_async_occ", b_occ, 3'd0);
    chk("b_async_stages", b_sv, 3'b000);
    chk("b_async_valid", b_ov, 1'b0);
    rst_n = 1'b1;
    @(negedge clk); chk("b_post_rst_occ", b_occ, 3'd0);

    // N=0 combinational feed-through.
    for (int i = 0; i < 6; i++) begin
      c_din = DW'($urandom);
      c_iv  = 1'(i);
      c_or  = 1'(i >> 1);
      #1;
      chk("c_data", c_dout, c_din);
      chk("c_valid", c_ov, c_iv);
      chk("c_ready", c_ir, c_or);
      chk("c_occ", c_occ, 1'b0);
      chk("c_stage_valid", c_sv, 1'b0);
      chk("c_busy", c_busy, c_iv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
